// File: rtl/sr_trace_fifo_pkg.sv
// Shared constants for the execution-trace FIFO: default sizing and the
// bit layout of one packed trace entry {cycle, pc, instr, a0}.
package sr_trace_fifo_pkg;

  localparam int DEF_DEPTH      = 16;
  localparam int DEF_CYCLE_W    = 16;
  localparam int DEF_MAX_CYCLES = 2000;
  localparam int DEF_DROP_W     = 8;

  localparam int A0_LSB    = 0;
  localparam int INSTR_LSB = 32;
  localparam int PC_LSB    = 64;
  localparam int CYCLE_LSB = 96;

  function automatic int entry_w(input int cycle_w);
    return CYCLE_LSB + cycle_w;
  endfunction

endpackage

// File: rtl/sr_trace_fifo_if.sv
// Drain-side valid/ready port of the trace FIFO; master is the FIFO,
// slave is the consumer (bench or debug UART).
interface sr_trace_fifo_if #(
  parameter int CYCLE_W = 16
);
  logic               out_valid;
  logic               out_ready;
  logic [CYCLE_W-1:0] out_cycle;
  logic [31:0]        out_pc;
  logic [31:0]        out_instr;
  logic [31:0]        out_a0;

  modport master (
    output out_valid, out_cycle, out_pc, out_instr, out_a0,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_cycle, out_pc, out_instr, out_a0,
    output out_ready
  );
endinterface

// File: rtl/sr_trace_mem.sv
// Register-array storage for trace entries: one synchronous write port and
// one asynchronous read port.
module sr_trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 112,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents need no reset because validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sr_trace_fifo.sv
// Trace capture FIFO downstream of the CPU: stamps each enabled cycle,
// buffers it for a non-stalling consumer, counts drops and flags timeout.
module sr_trace_fifo
  import sr_trace_fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CYCLE_W    = DEF_CYCLE_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int DROP_W     = DEF_DROP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_en,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic [31:0]              a0,
  sr_trace_fifo_if.master          trc,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        dropped,
  output logic                     timeout
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LVL_W   = AW + 1;
  localparam int ENTRY_W = entry_w(CYCLE_W);

  logic [AW-1:0]      head_r;
  logic [AW-1:0]      tail_r;
  logic [LVL_W-1:0]   level_r;
  logic [CYCLE_W-1:0] cycle_r;
  logic [DROP_W-1:0]  dropped_r;
  logic               timeout_r;
  logic               valid_r;

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_s;
  logic               drop_s;
  logic               hit_max_s;
  logic [LVL_W-1:0]   level_nxt_s;
  logic [CYCLE_W-1:0] cycle_nxt_s;
  logic [ENTRY_W-1:0] wdata_s;
  logic [ENTRY_W-1:0] rdata_s;

  // Push/pop decisions; a push into a full FIFO only lands if the head leaves this cycle.
  always_comb begin
    push_s      = trace_en & ~timeout_r;
    pop_s       = valid_r & trc.out_ready;
    full_s      = (level_r == LVL_W'(DEPTH));
    wr_s        = push_s & (~full_s | pop_s);
    drop_s      = push_s & full_s & ~pop_s;
    level_nxt_s = level_r + LVL_W'(wr_s) - LVL_W'(pop_s);
    cycle_nxt_s = cycle_r + CYCLE_W'(1);
    hit_max_s   = (MAX_CYCLES != 0) && (cycle_nxt_s == CYCLE_W'(MAX_CYCLES));
    wdata_s                          = '0;
    wdata_s[CYCLE_LSB +: CYCLE_W]    = cycle_r;
    wdata_s[PC_LSB +: 32]            = pc;
    wdata_s[INSTR_LSB +: 32]         = instr;
    wdata_s[A0_LSB +: 32]            = a0;
  end

  sr_trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_s),
    .waddr (tail_r),
    .wdata (wdata_s),
    .raddr (head_r),
    .rdata (rdata_s)
  );

  // Pointers, occupancy, cycle stamp, drop counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r    <= '0;
      tail_r    <= '0;
      level_r   <= '0;
      cycle_r   <= '0;
      dropped_r <= '0;
      timeout_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      if (wr_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      level_r <= level_nxt_s;
      valid_r <= (level_nxt_s != '0);
      // Dropped pushes still consume a cycle stamp so gaps are visible downstream.
      if (push_s) begin
        cycle_r <= cycle_nxt_s;
        if (hit_max_s) begin
          timeout_r <= 1'b1;
        end
      end
      if (drop_s && (dropped_r != '1)) begin
        dropped_r <= dropped_r + DROP_W'(1);
      end
    end
  end

  // Payload is forced to zero while empty so reset leaves clean outputs.
  always_comb begin
    trc.out_cycle = '0;
    trc.out_pc    = '0;
    trc.out_instr = '0;
    trc.out_a0    = '0;
    if (valid_r) begin
      trc.out_cycle = rdata_s[CYCLE_LSB +: CYCLE_W];
      trc.out_pc    = rdata_s[PC_LSB +: 32];
      trc.out_instr = rdata_s[INSTR_LSB +: 32];
      trc.out_a0    = rdata_s[A0_LSB +: 32];
    end else begin
      trc.out_cycle = '0;
      trc.out_pc    = '0;
      trc.out_instr = '0;
      trc.out_a0    = '0;
    end
  end

  assign trc.out_valid = valid_r;
  assign level         = level_r;
  assign dropped       = dropped_r;
  assign timeout       = timeout_r;

endmodule

// File: tb/tb_sr_trace_fifo.sv
// Directed scoreboard bench: dut0 uses the default timeout, dut1 uses MAX_CYCLES = 10.
module tb_sr_trace_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] a0;
  logic [1:0]  en;
  logic [1:0]  rdy;

  logic [1:0]        vld;
  logic [1:0][15:0]  ocyc;
  logic [1:0][31:0]  opc;
  logic [1:0][31:0]  oins;
  logic [1:0][31:0]  oa0;
  logic [1:0][4:0]   lvl;
  logic [1:0][7:0]   drp;
  logic [1:0]        to;

  sr_trace_fifo_if #(.CYCLE_W(16)) tif0 ();
  sr_trace_fifo_if #(.CYCLE_W(16)) tif1 ();

  sr_trace_fifo #(.DEPTH(16), .CYCLE_W(16), .MAX_CYCLES(2000), .DROP_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .trace_en(en[0]), .pc(pc), .instr(instr), .a0(a0),
    .trc(tif0), .level(lvl[0]), .dropped(drp[0]), .timeout(to[0])
  );

  sr_trace_fifo #(.DEPTH(16), .CYCLE_W(16), .MAX_CYCLES(10), .DROP_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .trace_en(en[1]), .pc(pc), .instr(instr), .a0(a0),
    .trc(tif1), .level(lvl[1]), .dropped(drp[1]), .timeout(to[1])
  );

  assign tif0.out_ready = rdy[0];
  assign tif1.out_ready = rdy[1];
  assign vld[0]  = tif0.out_valid;
  assign vld[1]  = tif1.out_valid;
  assign ocyc[0] = tif0.out_cycle;
  assign ocyc[1] = tif1.out_cycle;
  assign opc[0]  = tif0.out_pc;
  assign opc[1]  = tif1.out_pc;
  assign oins[0] = tif0.out_instr;
  assign oins[1] = tif1.out_instr;
  assign oa0[0]  = tif0.out_a0;
  assign oa0[1]  = tif1.out_a0;

  int          checks = 0;
  int          errors = 0;
  int          m_level [2];
  int          m_drop  [2];
  logic [15:0] m_cycle [2];
  bit          m_to    [2];
  logic [111:0] q0 [$];
  logic [111:0] q1 [$];

  function automatic int maxc(input int d);
    return (d == 0) ? 2000 : 10;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_state();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("level%0d", d),   128'(lvl[d]), 128'(m_level[d]));
      chk($sformatf("valid%0d", d),   128'(vld[d]), 128'(m_level[d] != 0));
      chk($sformatf("dropped%0d", d), 128'(drp[d]), 128'(m_drop[d]));
      chk($sformatf("timeout%0d", d), 128'(to[d]),  128'(m_to[d]));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 2'b00;
    rdy   = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_level[d] = 0;
      m_drop[d]  = 0;
      m_cycle[d] = 16'd0;
      m_to[d]    = 1'b0;
    end
    q0.delete();
    q1.delete();
    check_state();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_cycle%0d", d), 128'(ocyc[d]), 128'(0));
      chk($sformatf("rst_pc%0d", d),    128'(opc[d]),  128'(0));
      chk($sformatf("rst_instr%0d", d), 128'(oins[d]), 128'(0));
      chk($sformatf("rst_a0%0d", d),    128'(oa0[d]),  128'(0));
    end
  endtask

  // One clock: drive inputs, score pops against the queue, advance the model, check state.
  task automatic step(input logic e0, input logic r0, input logic e1, input logic r1,
                      input logic [31:0] p);
    logic [111:0] ev;
    logic [111:0] ov;
    bit           pop;
    bit           push;
    en    = {e1, e0};
    rdy   = {r1, r0};
    pc    = p;
    instr = p ^ 32'hA5A5_0000;
    a0    = p + 32'd1000;
    for (int d = 0; d < 2; d++) begin
      pop  = (m_level[d] != 0) && rdy[d];
      push = en[d] && !m_to[d];
      if (pop) begin
        if (d == 0) ev = q0.pop_front();
        else        ev = q1.pop_front();
        ov = {ocyc[d], opc[d], oins[d], oa0[d]};
        chk($sformatf("pop%0d", d), 128'(ov), 128'(ev));
        m_level[d]--;
      end
      if (push) begin
        if (m_level[d] < DEPTH) begin
          if (d == 0) q0.push_back({m_cycle[d], pc, instr, a0});
          else        q1.push_back({m_cycle[d], pc, instr, a0});
          m_level[d]++;
        end else if (m_drop[d] < 255) begin
          m_drop[d]++;
        end
        m_cycle[d] = m_cycle[d] + 16'd1;
        if (m_cycle[d] == 16'(maxc(d))) m_to[d] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 2'b00;
    rdy   = 2'b00;
    pc    = 32'd0;
    instr = 32'd0;
    a0    = 32'd0;

    do_reset();

    // Three captures with no consumer
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'(i * 4));
    chk("t1_level", 128'(lvl[0]), 128'(3));
    chk("t1_cycle", 128'(ocyc[0]), 128'(0));
    chk("t1_pc",    128'(opc[0]),  128'(0));

    // Overfill by five, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH + 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(i * 4));
    chk("t2_level",   128'(lvl[0]), 128'(16));
    chk("t2_dropped", 128'(drp[0]), 128'(5));
    chk("t2_head_cycle", 128'(ocyc[0]), 128'(0));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t2_empty", 128'(vld[0]), 128'(0));

    // Streaming: consumer always ready
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000 + 32'(i * 4));
      chk("t3_level_le1", 128'(lvl[0] <= 5'd1), 128'(1));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000 + 32'(i * 4));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h3FFC);
    chk("t4_level",   128'(lvl[0]), 128'(16));
    chk("t4_dropped", 128'(drp[0]), 128'(5));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Timeout on dut1 after ten captures
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h4000 + 32'(i * 4));
      if (i == 8) chk("t5_to_before", 128'(to[1]), 128'(0));
      if (i == 9) chk("t5_to_at10",   128'(to[1]), 128'(1));
    end
    chk("t5_level", 128'(lvl[1]), 128'(10));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t5_drained", 128'(vld[1]), 128'(0));

    // Reset with seven entries held
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h5000 + 32'(i * 4));
    chk("t6_level_pre", 128'(lvl[0]), 128'(7));
    do_reset();
    chk("t6_level", 128'(lvl[0]), 128'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
